rom_prefetch_master: RTL and testbench

Instruction-fetch initiator for the dual boot/application ROM port. It issues pipelined strobe/address requests to the ROM and tracks the one-cycle-latency acknowledges. Returned words go into a small FIFO that is presented to the CPU front end as a valid/ready instruction stream, with a PC tag on each word. It sits between the core's fetch stage and the ROM slave, and supports PC redirects (branches, traps) and fetch enable/stall.

---
 rtl/rom_prefetch_master.sv | 103 ++++++++++
 tb/tb_rom_prefetch_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_prefetch_master.sv
// rom_prefetch_master: pipelined instruction prefetcher for the ROM port.
// Issues strobe/address requests, buffers acked words with their PC tags.
module rom_prefetch_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_stb,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  rom_ack,
    input  logic                  enable,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  insn_valid,
    output logic [DATA_WIDTH-1:0] insn_data,
    output logic [ADDR_WIDTH-1:0] insn_pc,
    input  logic                  insn_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic                  r_inflight;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_mem_pc   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];

    logic [CW-1:0] w_occ;
    logic          w_stb;
    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;

    // Occupancy includes the outstanding request so a push never overflows;
    // a same-cycle pop earns no credit, keeping insn_ready off the strobe path.
    assign w_occ      = r_count + CW'(r_inflight);
    assign w_stb      = rst_n & enable & ~redirect & (w_occ < CW'(FIFO_DEPTH));
    assign w_push     = r_inflight & rom_ack & ~redirect;
    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty & ~redirect & insn_ready;

    assign rom_stb    = w_stb;
    assign rom_addr   = r_fetch_pc;
    assign insn_valid = w_nonempty & ~redirect;
    assign insn_data  = w_nonempty ? r_mem_data[r_rd_ptr] : '0;
    assign insn_pc    = w_nonempty ? r_mem_pc[r_rd_ptr] : '0;

    // Request side: advance the fetch PC per strobe, remember what is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc & ~ADDR_WIDTH'(3);
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_stb;
            if (w_stb) begin
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
                r_req_pc   <= r_fetch_pc;
            end
        end
    end

    // Buffer bookkeeping: pointers and count, flushed by reset or redirect.
    always_ff @(posedge clk) begin
        if (!rst_n || redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Buffer storage: tagged words written at the tail on each accepted ack.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
            r_mem_data[r_wr_ptr] <= rom_data;
        end
    end

endmodule

// File: tb/tb_rom_prefetch_master.sv
// tb_rom_prefetch_master: directed vectors for the ROM prefetcher.
// A behavioural ROM acks every strobe one cycle later.
module tb_rom_prefetch_master;

    logic        clk;
    logic        rst_n;
    logic [14:0] rom_addr;
    logic        rom_stb;
    logic [31:0] rom_data;
    logic        rom_ack;
    logic        enable;
    logic        redirect;
    logic [14:0] redirect_pc;
    logic        insn_valid;
    logic [31:0] insn_data;
    logic [14:0] insn_pc;
    logic        insn_ready;
    logic        inj_ack;

    int n_vec;
    int n_err;

    rom_prefetch_master dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_stb     (rom_stb),
        .rom_data    (rom_data),
        .rom_ack     (rom_ack),
        .enable      (enable),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .insn_valid  (insn_valid),
        .insn_data   (insn_data),
        .insn_pc     (insn_pc),
        .insn_ready  (insn_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Boot words below 0x4000, application words from 0x4000 up.
    function automatic logic [31:0] rom_word(input logic [14:0] a);
        logic [14:0] off;
        if (a >= 15'h4000) begin
            off = a - 15'h4000;
            return 32'hB000_0000 + 32'(off >> 2);
        end
        return 32'hA000_0000 + 32'(a >> 2);
    endfunction

    // ROM slave model: one-cycle ack latency, optional injected stray ack.
    initial begin
        rom_ack  = 1'b0;
        rom_data = '0;
    end
    always @(posedge clk) begin
        rom_ack  <= rom_stb | inj_ack;
        rom_data <= inj_ack ? 32'hDEAD_BEEF : rom_word(rom_addr);
    end

    typedef struct {
        bit          rst;
        bit          en;
        bit          rdy;
        bit          stb;
        logic [14:0] addr;
        bit          vld;
        logic [14:0] pc;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl[$];

    task automatic drive(input bit r, input bit en, input bit rdy,
                         input bit rd, input logic [14:0] rpc);
        rst_n       = r;
        enable      = en;
        insn_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic chk(input string nm, input bit e_stb,
                       input logic [14:0] e_addr, input bit e_vld,
                       input logic [14:0] e_pc, input logic [31:0] e_dat,
                       input bit all);
        bit bad;
        n_vec++;
        bad = (rom_stb !== e_stb) || (insn_valid !== e_vld);
        if ((e_stb || all) && (rom_addr !== e_addr)) bad = 1'b1;
        if ((e_vld || all) && ((insn_pc !== e_pc) || (insn_data !== e_dat)))
            bad = 1'b1;
        if (bad) begin
            n_err++;
            $display("FAIL %s: got stb=%0b addr=%h vld=%0b pc=%h data=%h, want stb=%0b addr=%h vld=%0b pc=%h data=%h",
                     nm, rom_stb, rom_addr, insn_valid, insn_pc, insn_data,
                     e_stb, e_addr, e_vld, e_pc, e_dat);
        end
    endtask

    task automatic do_reset();
        inj_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
        @(negedge clk);
        #1;
        chk("reset", 1'b0, 15'h0, 1'b0, 15'h0, 32'h0, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        inj_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 15'h0);

        // sequential fetch
        tbl.push_back('{1, 1, 1, 1, 15'h0000, 0, 15'h0000, 32'h0});
        tbl.push_back('{0, 1, 1, 1, 15'h0004, 0, 15'h0000, 32'h0});
        tbl.push_back('{0, 1, 1, 1, 15'h0008, 1, 15'h0000, 32'hA000_0000});
        tbl.push_back('{0, 1, 1, 1, 15'h000C, 1, 15'h0004, 32'hA000_0001});
        tbl.push_back('{0, 1, 1, 1, 15'h0010, 1, 15'h0008, 32'hA000_0002});
        tbl.push_back('{0, 1, 1, 1, 15'h0014, 1, 15'h000C, 32'hA000_0003});
        tbl.push_back('{0, 1, 1, 1, 15'h0018, 1, 15'h0010, 32'hA000_0004});
        tbl.push_back('{0, 1, 1, 1, 15'h001C, 1, 15'h0014, 32'hA000_0005});
        // backpressure: fill to depth, then drain
        tbl.push_back('{1, 1, 0, 1, 15'h0000, 0, 15'h0000, 32'h0});
        tbl.push_back('{0, 1, 0, 1, 15'h0004, 0, 15'h0000, 32'h0});
        tbl.push_back('{0, 1, 0, 1, 15'h0008, 1, 15'h0000, 32'hA000_0000});
        tbl.push_back('{0, 1, 0, 1, 15'h000C, 1, 15'h0000, 32'hA000_0000});
        tbl.push_back('{0, 1, 0, 0, 15'h0010, 1, 15'h0000, 32'hA000_0000});
        tbl.push_back('{0, 1, 0, 0, 15'h0010, 1, 15'h0000, 32'hA000_0000});
        tbl.push_back('{0, 1, 0, 0, 15'h0010, 1, 15'h0000, 32'hA000_0000});
        tbl.push_back('{0, 1, 1, 0, 15'h0010, 1, 15'h0000, 32'hA000_0000});
        tbl.push_back('{0, 1, 1, 1, 15'h0010, 1, 15'h0004, 32'hA000_0001});
        tbl.push_back('{0, 1, 1, 1, 15'h0014, 1, 15'h0008, 32'hA000_0002});
        tbl.push_back('{0, 1, 1, 1, 15'h0018, 1, 15'h000C, 32'hA000_0003});
        tbl.push_back('{0, 1, 1, 1, 15'h001C, 1, 15'h0010, 32'hA000_0004});
        tbl.push_back('{0, 1, 1, 1, 15'h0020, 1, 15'h0014, 32'hA000_0005});

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            drive(1'b1, tbl[i].en, tbl[i].rdy, 1'b0, 15'h0);
            chk($sformatf("vec%0d", i), tbl[i].stb, tbl[i].addr,
                tbl[i].vld, tbl[i].pc, tbl[i].dat, 1'b0);
            @(negedge clk);
        end

        // redirect while an ack is in flight
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
            @(negedge clk);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 15'h4002);
        chk("redir_cyc", 1'b0, 15'h0, 1'b0, 15'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("redir_r1", 1'b1, 15'h4000, 1'b0, 15'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("redir_r2", 1'b1, 15'h4004, 1'b0, 15'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("redir_r3", 1'b1, 15'h4008, 1'b1, 15'h4000, 32'hB000_0000, 1'b0);
        @(negedge clk);

        // wrap-around at top of ROM
        drive(1'b1, 1'b1, 1'b1, 1'b1, 15'h7FFC);
        chk("wrap_cyc", 1'b0, 15'h0, 1'b0, 15'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("wrap_r1", 1'b1, 15'h7FFC, 1'b0, 15'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("wrap_r2", 1'b1, 15'h0000, 1'b0, 15'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("wrap_r3", 1'b1, 15'h0004, 1'b1, 15'h7FFC, 32'hB000_0FFF, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("wrap_r4", 1'b1, 15'h0008, 1'b1, 15'h0000, 32'hA000_0000, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("wrap_r5", 1'b1, 15'h000C, 1'b1, 15'h0004, 32'hA000_0001, 1'b0);
        @(negedge clk);

        // enable drop with a request in flight
        drive(1'b1, 1'b0, 1'b1, 1'b0, 15'h0);
        chk("en_off0", 1'b0, 15'h0, 1'b1, 15'h0008, 32'hA000_0002, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 15'h0);
        chk("en_off1", 1'b0, 15'h0, 1'b1, 15'h000C, 32'hA000_0003, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 15'h0);
        chk("en_off2", 1'b0, 15'h0, 1'b0, 15'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("en_on0", 1'b1, 15'h0010, 1'b0, 15'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("en_on1", 1'b1, 15'h0014, 1'b0, 15'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("en_on2", 1'b1, 15'h0018, 1'b1, 15'h0010, 32'hA000_0004, 1'b0);
        @(negedge clk);

        // reset mid-stream with 3 words buffered and one in flight
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 15'h0);
            @(negedge clk);
        end
        inj_ack = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 15'h0);
        @(negedge clk);
        inj_ack = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 15'h0);
        chk("mrst_r0", 1'b1, 15'h0000, 1'b0, 15'h0, 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 15'h0);
        chk("mrst_r1", 1'b1, 15'h0004, 1'b0, 15'h0, 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 15'h0);
        chk("mrst_r2", 1'b1, 15'h0008, 1'b1, 15'h0000, 32'hA000_0000, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("mrst_r3", 1'b1, 15'h000C, 1'b1, 15'h0000, 32'hA000_0000, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
        chk("mrst_r4", 1'b1, 15'h0010, 1'b1, 15'h0004, 32'hA000_0001, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
